// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver -- oversampled serial byte receiver with a one-byte output register.
//
// Line format (after the input synchronizer):
//   idle = 0, start bit = 1, eight data bits LSB first, stop bit = 0,
//   every bit lasting BIT_CYCLES clocks.
//
// The start bit is confirmed at its midpoint. Each data bit and the stop bit
// are then sampled one full bit period later, which is again mid-bit. A frame
// with a good stop bit is a "good frame". It is offered to the consumer
// through a valid/ready register. A frame with a bad (high) stop bit is
// discarded, and the receiver then waits for the line to return low so that
// a stuck-high line cannot start a new frame.
//
// Parameters
//   BIT_CYCLES   clock cycles per serial bit (4 .. 2^32-1)
//   SYNC_STAGES  depth of the rx_line synchronizer (2 .. 4)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_line    asynchronous serial input
//   rx_data    last accepted byte
//   rx_valid   rx_data holds a byte the consumer has not taken yet
//   rx_ready   consumer takes rx_data this cycle (ignored while rx_valid=0)
//   frame_err  one-cycle pulse when a frame ends with a bad stop bit
//   overrun    one-cycle pulse when a good frame is dropped because the
//              previous byte was still unconsumed
//   led        display copy of rx_data
// -----------------------------------------------------------------------------
module receiver #(
  parameter int unsigned BIT_CYCLES  = 10_000_001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] led
);

  // Counter compare points. Both are full 32-bit constants, so the counter
  // never needs to wrap for any legal BIT_CYCLES.
  localparam logic [31:0] HALF_CNT = 32'(BIT_CYCLES / 2 - 1);
  localparam logic [31:0] LAST_CNT = 32'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_LOW
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. The oldest stage is the only view of the line that
  // the rest of the design uses.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   line;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_line};
  assign line   = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receive state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // clocks elapsed in the current bit
  logic [2:0]  idx_q, idx_d;       // next data bit position to fill
  logic [7:0]  shift_q, shift_d;   // byte being assembled

  // Output register state
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  led_q, led_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  // Frame completion events. Each is high for the single cycle in which the
  // stop bit is judged.
  logic        good_frame;
  logic        bad_frame;

  // ---------------------------------------------------------------------------
  // Next-state logic for the receive FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves a variable unassigned in always_comb infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (line) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        // Confirm the start bit at its midpoint. A pulse that has already
        // gone away is a glitch. It produces no output activity.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (line) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          shift_d[idx_q] = line;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!line) begin
            good_frame = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bad_frame = 1'b1;
            state_d   = S_WAIT_LOW;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_WAIT_LOW: begin
        // After a bad stop bit the line may be stuck high. Wait for it to
        // drop before a new start edge can be recognised.
        if (!line) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register / handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_data_d   = rx_data_q;
    led_d       = led_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = bad_frame;
    overrun_d   = 1'b0;

    if (good_frame && (!rx_valid_q || rx_ready)) begin
      // The register is empty, or it is emptied in this same cycle, so the
      // new byte replaces it without a gap.
      rx_data_d  = shift_q;
      led_d      = shift_q;
      rx_valid_d = 1'b1;
    end else if (good_frame) begin
      // The previous byte is still pending. Keep it and drop the new one.
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge, whatever order the statements
  // are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every flop, including the byte assembly register, has a defined
      // reset value. A partial frame is therefore discarded and cannot leak
      // into the next good frame.
      sync_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      led_q       <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      led_q       <= led_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign led       = led_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver -- self-checking bench for receiver (BIT_CYCLES=16,
// SYNC_STAGES=2).
//
// The reference model works at frame level. Each frame sent is logged with
// the cycle on which its result must appear. That cycle follows from the
// sampling rule (start bit confirmed at mid-bit, then nine full bit periods,
// plus synchronizer delay and one output register). A per-cycle compare
// process applies the handshake rules to these frame results and checks
// every DUT output on every cycle. Directed literal checks fix the absolute
// latency and the expected bytes and pulse counts.
// -----------------------------------------------------------------------------
module tb_receiver;

  localparam int BIT  = 16;
  localparam int SYNC = 2;
  localparam int HALF = BIT / 2;
  // Cycle on which a frame's result is visible, counted from the cycle the
  // start bit is first driven.
  localparam int DONE_LAT = SYNC + HALF + 9 * BIT + 1;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_line  = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [7:0] led;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  receiver #(
    .BIT_CYCLES (BIT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_line  (rx_line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .led      (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int         due;
    logic [7:0] data;
    bit         good;
  } ev_t;

  ev_t        evq[$];
  ev_t        cur_ev;
  logic [7:0] m_data     = '0;
  bit         m_valid    = 1'b0;
  bit         m_ferr     = 1'b0;
  bit         m_ovr      = 1'b0;
  bit         m_rdy_prev = 1'b0;

  // Observed-event statistics for the directed checks
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_log[$];
  logic       prev_v   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      evq.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        cur_ev = evq.pop_front();
        if (!cur_ev.good) begin
          m_ferr = 1'b1;
        end else if (!m_valid || m_rdy_prev) begin
          m_valid = 1'b1;
          m_data  = cur_ev.data;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && m_rdy_prev) begin
        m_valid = 1'b0;
      end
    end

    check("rx_valid",  32'(rx_valid),  32'(m_valid));
    check("rx_data",   32'(rx_data),   32'(m_data));
    check("led",       32'(led),       32'(m_data));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("overrun",   32'(overrun),   32'(m_ovr));

    m_rdy_prev = rx_ready;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
      rise_log.push_back(rx_data);
    end
    prev_v = rx_valid;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    evq.push_back('{due: cyc + DONE_LAT, data: b, good: !stop_bit});
    rx_line = 1'b1;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      tick(BIT);
    end
    rx_line = stop_bit;
    tick(BIT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int         t0;
  int         f0;
  int         o0;
  int         r0;
  logic [7:0] l0;
  logic [7:0] l1;

  initial begin
    // Reset state
    tick(3);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data",  32'(rx_data),  32'd0);
    check("reset_led",   32'(led),      32'd0);
    rst_n = 1'b1;
    tick(10);

    // 0xB3, rx_ready low
    t0 = cyc;
    send_frame(8'hB3, 1'b0);
    tick(4);
    check("b3_valid",   32'(rx_valid), 32'd1);
    check("b3_data",    32'(rx_data),  32'hB3);
    check("b3_led",     32'(led),      32'hB3);
    check("b3_ferr",    32'(ferr_cnt), 32'd0);
    check("b3_latency", 32'(rise_cyc - t0), 32'd155);

    // One-cycle consume
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("consume_valid", 32'(rx_valid), 32'd0);
    check("consume_hold",  32'(rx_data),  32'hB3);
    tick(5);

    // Four-cycle glitch from idle
    r0 = rise_cnt;
    rx_line = 1'b1;
    tick(4);
    rx_line = 1'b0;
    tick(30);
    check("glitch_rise", 32'(rise_cnt - r0), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);

    // 0x5A with a bad stop bit, line held high, then low
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1);
    tick(40);
    rx_line = 1'b0;
    tick(200);
    check("ferr_once",  32'(ferr_cnt - f0), 32'd1);
    check("ferr_valid", 32'(rx_valid), 32'd0);
    check("ferr_rise",  32'(rise_cnt - r0), 32'd0);

    // 0x11 held, then 0x22 is dropped
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    tick(5);
    check("ovr_once",  32'(ovr_cnt - o0), 32'd1);
    check("ovr_data",  32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_consume", 32'(rx_valid), 32'd0);
    tick(5);

    // Reset during data bit 4 of 0x0F
    rx_line = 1'b1;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_line = 1'b1;
      tick(BIT);
    end
    rx_line = 1'b0;
    tick(HALF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data",  32'(rx_data),   32'd0);
    check("rst_led",   32'(led),       32'd0);
    check("rst_valid", 32'(rx_valid),  32'd0);
    check("rst_ferr",  32'(frame_err), 32'd0);
    check("rst_ovr",   32'(overrun),   32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    send_frame(8'hC3, 1'b0);
    tick(3);
    check("c3_data",  32'(rx_data),  32'hC3);
    check("c3_led",   32'(led),      32'hC3);
    check("c3_valid", 32'(rx_valid), 32'd1);

    // Back-to-back 0x01, 0x80 with rx_ready tied high
    rx_ready = 1'b1;
    tick(3);
    rise_log.delete();
    r0 = rise_cnt;
    o0 = ovr_cnt;
    send_frame(8'h01, 1'b0);
    send_frame(8'h80, 1'b0);
    tick(5);
    l0 = (rise_log.size() > 0) ? rise_log[0] : 8'hxx;
    l1 = (rise_log.size() > 1) ? rise_log[1] : 8'hxx;
    check("b2b_rises", 32'(rise_cnt - r0), 32'd2);
    check("b2b_first", 32'(l0), 32'h01);
    check("b2b_second", 32'(l1), 32'h80);
    check("b2b_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("b2b_valid", 32'(rx_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
